// File: rtl/patch_sum_collector.sv
// Collects row-reducer sums round-robin into per-patch accumulators and emits finished patch totals.
// Optional: define PATCH_SUM_SATURATE_EN to make accumulators saturate instead of wrapping.
module patch_acc #(
  parameter int ROW_SUM_SIZE   = 32,
  parameter int PATCH_SUM_SIZE = 36,
  parameter int PATCH_SIZE     = 6,
  parameter int RW             = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      add,
  input  logic                      clr,
  input  logic [ROW_SUM_SIZE-1:0]   sum,
  input  logic [1:0]                nrows,
  output logic [PATCH_SUM_SIZE-1:0] acc,
  output logic                      done,
  output logic                      over
);
  logic [RW-1:0]             rows, rows_nxt;
  logic [PATCH_SUM_SIZE-1:0] acc_nxt;

`ifdef PATCH_SUM_SATURATE_EN
  logic [PATCH_SUM_SIZE:0] sum_ext;
  assign sum_ext = {1'b0, acc} + (PATCH_SUM_SIZE+1)'(sum);
  assign acc_nxt = sum_ext[PATCH_SUM_SIZE] ? '1 : sum_ext[PATCH_SUM_SIZE-1:0];
`else
  assign acc_nxt = acc + PATCH_SUM_SIZE'(sum);
`endif

  assign rows_nxt = rows + RW'(nrows);
  assign over     = add && (rows_nxt > RW'(PATCH_SIZE));

  // add and clr never hit the same patch: a done patch is masked from arbitration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      rows <= '0;
      done <= 1'b0;
    end else if (clr) begin
      acc  <= '0;
      rows <= '0;
      done <= 1'b0;
    end else if (add) begin
      acc  <= acc_nxt;
      rows <= rows_nxt;
      done <= (rows_nxt >= RW'(PATCH_SIZE));
    end
  end
endmodule

module patch_sum_collector #(
  parameter int N_ROW_REDUCER   = 4,
  parameter int N_PATCH_REDUCER = 2,
  parameter int PATCH_SIZE      = 6,
  parameter int ROW_SUM_SIZE    = 32,
  parameter int PATCH_SUM_SIZE  = 36,
  localparam int OW = (N_PATCH_REDUCER > 1) ? $clog2(N_PATCH_REDUCER) : 1
) (
  input  logic                                        dram_clk,
  input  logic                                        reset,
  input  logic [N_ROW_REDUCER-1:0][1:0]               row_sum_rdy,
  input  logic [N_ROW_REDUCER-1:0][ROW_SUM_SIZE-1:0]  row_sum,
  input  logic [N_ROW_REDUCER-1:0][OW-1:0]            row_owner,
  output logic [N_ROW_REDUCER-1:0]                    row_sum_ack,
  output logic                                        patch_valid,
  input  logic                                        patch_ready,
  output logic [OW-1:0]                               patch_id,
  output logic [PATCH_SUM_SIZE-1:0]                   patch_sum,
  output logic                                        overrun
);
  localparam int RW = $clog2(PATCH_SIZE*2) + 1;
  localparam int PW = (N_ROW_REDUCER > 1) ? $clog2(N_ROW_REDUCER) : 1;

  logic [N_PATCH_REDUCER-1:0][PATCH_SUM_SIZE-1:0] acc;
  logic [N_PATCH_REDUCER-1:0] done, over, clr;
  logic [N_ROW_REDUCER-1:0]   elig;
  logic [PW-1:0] rr_ptr, gnt_idx, cand;
  logic          gnt, any_done, load_ok;
  logic [OW-1:0] sel;

  always_comb begin
    for (int i = 0; i < N_ROW_REDUCER; i++)
      elig[i] = (|row_sum_rdy[i]) && !done[row_owner[i]];
  end

  // first eligible reducer after the last one granted
  always_comb begin
    gnt     = 1'b0;
    gnt_idx = rr_ptr;
    cand    = '0;
    for (int k = 1; k <= N_ROW_REDUCER; k++) begin
      cand = PW'((int'(rr_ptr) + k) % N_ROW_REDUCER);
      if (!gnt && elig[cand]) begin
        gnt     = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    row_sum_ack = '0;
    if (gnt && !reset) row_sum_ack[gnt_idx] = 1'b1;
  end

  // lowest-index finished patch wins the output register
  always_comb begin
    any_done = 1'b0;
    sel      = '0;
    for (int p = N_PATCH_REDUCER-1; p >= 0; p--)
      if (done[p]) begin
        any_done = 1'b1;
        sel      = OW'(p);
      end
  end

  assign load_ok = !patch_valid || patch_ready;

  for (genvar p = 0; p < N_PATCH_REDUCER; p++) begin : g_patch
    assign clr[p] = load_ok && any_done && (sel == OW'(p));
    patch_acc #(
      .ROW_SUM_SIZE  (ROW_SUM_SIZE),
      .PATCH_SUM_SIZE(PATCH_SUM_SIZE),
      .PATCH_SIZE    (PATCH_SIZE),
      .RW            (RW)
    ) u_acc (
      .clk  (dram_clk),
      .rst  (reset),
      .add  (gnt && (row_owner[gnt_idx] == OW'(p))),
      .clr  (clr[p]),
      .sum  (row_sum[gnt_idx]),
      .nrows(row_sum_rdy[gnt_idx]),
      .acc  (acc[p]),
      .done (done[p]),
      .over (over[p])
    );
  end

  always_ff @(posedge dram_clk or posedge reset) begin
    if (reset) begin
      rr_ptr      <= PW'(N_ROW_REDUCER-1);
      patch_valid <= 1'b0;
      patch_id    <= '0;
      patch_sum   <= '0;
      overrun     <= 1'b0;
    end else begin
      if (gnt) rr_ptr <= gnt_idx;
      if (|over) overrun <= 1'b1;
      if (load_ok) begin
        patch_valid <= any_done;
        if (any_done) begin
          patch_id  <= sel;
          patch_sum <= acc[sel];
        end
      end
    end
  end
endmodule
